// File: rtl/pattern_detect_pkg.sv
// Shared types and helpers for the serial bit-pattern detector sequencer.
package pattern_detect_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_UNCFG   = 2'b00,
        ST_FILL    = 2'b01,
        ST_ILLEGAL = 2'b10,
        ST_HUNT    = 2'b11
    } state_e;

    typedef struct packed {
        logic j;
        logic k;
    } jk_t;

    // Drive a JK cell from its present value to the wanted next value.
    function automatic jk_t jk_excite(input logic q, input logic nxt);
        jk_t r;
        r.j = nxt & ~q;
        r.k = ~nxt & q;
        return r;
    endfunction

endpackage

// File: rtl/pattern_detect_ctrl_jk_state_reg.sv
// N-bit bank of JK flip-flops with synchronous active-high reset.
module jk_state_reg #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] j,
    input  logic [N-1:0] k,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = '0;
        for (int i = 0; i < N; i++) begin
            q_d[i] = (j[i] & ~q_q[i]) | (~k[i] & q_q[i]);
        end
    end

    // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Serial bit-pattern detector sequencer: JK-based FILL/HUNT state, registered match pulse.
// Optional saturating match counter enabled by defining PATTERN_DETECT_MATCH_CNT_EN.
module pattern_detect_ctrl
    import pattern_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clr_count,
    output logic             armed,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int                FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);

    state_e           state_q, state_d;
    logic [1:0]       st_raw, st_j, st_k;
    jk_t              jk_bit;

    logic [PAT_W-1:0] window_q, window_d, shifted;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
    logic             overlap_q, overlap_d;
    logic             match_q, match_d;
    logic             armed_q, armed_d;

    // State register: JK bank, reset forces UNCFG (00).
    jk_state_reg #(.N(2)) u_state (
        .clk   (clk),
        .reset (reset),
        .j     (st_j),
        .k     (st_k),
        .q     (st_raw)
    );

    assign state_q = state_e'(st_raw);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            window_q  <= '0;
            pattern_q <= '0;
            fill_q    <= '0;
            overlap_q <= 1'b0;
            match_q   <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            window_q  <= window_d;
            pattern_q <= pattern_d;
            fill_q    <= fill_d;
            overlap_q <= overlap_d;
            match_q   <= match_d;
            armed_q   <= armed_d;
        end
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        window_d  = window_q;
        pattern_d = pattern_q;
        fill_d    = fill_q;
        overlap_d = overlap_q;
        match_d   = 1'b0;
        shifted   = {window_q[PAT_W-2:0], bit_in};
        fill_inc  = fill_q + 1'b1;

        case (state_q)
            ST_UNCFG: begin
                if (cfg_load) begin
                    pattern_d = cfg_pattern;
                    overlap_d = cfg_overlap;
                    window_d  = '0;
                    fill_d    = '0;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL, ST_HUNT: begin
                // A reload drops any bit offered in the same cycle.
                if (cfg_load) begin
                    pattern_d = cfg_pattern;
                    overlap_d = cfg_overlap;
                    window_d  = '0;
                    fill_d    = '0;
                    state_d   = ST_FILL;
                end else if (bit_valid) begin
                    window_d = shifted;
                    fill_d   = (state_q == ST_HUNT) ? FULL : fill_inc;
                    if (fill_d == FULL) begin
                        state_d = ST_HUNT;
                        if (shifted == pattern_q) begin
                            match_d = 1'b1;
                            if (!overlap_q) begin
                                window_d = '0;
                                fill_d   = '0;
                                state_d  = ST_FILL;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_UNCFG;
        endcase
    end

    always_comb begin
        st_j    = '0;
        st_k    = '0;
        jk_bit  = '0;
        for (int i = 0; i < 2; i++) begin
            jk_bit  = jk_excite(state_q[i], state_d[i]);
            st_j[i] = jk_bit.j;
            st_k[i] = jk_bit.k;
        end
        armed_d = (state_d != ST_UNCFG);
    end

    assign match = match_q;
    assign armed = armed_q;

`ifdef PATTERN_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    // Clear is applied before the increment, so clear plus a pulse yields one.
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr_count) begin
            count_d = '0;
            sat_d   = 1'b0;
        end
        if (match_q && (count_d != '1)) begin
            count_d = count_d + 1'b1;
        end
        if (match_q && (count_d == '1)) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign match_count = count_q;
    assign count_sat   = sat_q;
`else
    logic unused_clr;

    assign unused_clr  = clr_count;
    assign match_count = {CNT_W{1'b0}};
    assign count_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Scoreboard bench for pattern_detect_ctrl (PAT_W=4, CNT_W=2); counter expectations follow PATTERN_DETECT_MATCH_CNT_EN.
module tb_pattern_detect_ctrl;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
`ifdef PATTERN_DETECT_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, cfg_load, cfg_overlap, bit_valid, bit_in, clr_count;
    logic [PAT_W-1:0] cfg_pattern;
    logic             armed, match, count_sat;
    logic [CNT_W-1:0] match_count;

    typedef struct {
        int               idx;
        logic             m;
        logic [CNT_W-1:0] c;
        logic             s;
        logic             a;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_n = 0;

    pattern_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .clr_count   (clr_count),
        .armed       (armed),
        .match       (match),
        .match_count (match_count),
        .count_sat   (count_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle and queue the outputs expected after the coming edge.
    task automatic cyc(input logic rst, input logic ld, input logic [3:0] pat, input logic ovl,
                       input logic bv, input logic bi, input logic clr,
                       input logic em, input int ec, input logic es, input logic ea);
        exp_t e;
        reset       = rst;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_overlap = ovl;
        bit_valid   = bv;
        bit_in      = bi;
        clr_count   = clr;
        step_n++;
        e.idx = step_n;
        e.m   = em;
        e.c   = CNT_EN ? ec[CNT_W-1:0] : '0;
        e.s   = CNT_EN ? es : 1'b0;
        e.a   = ea;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic bi, input logic em, input int ec, input logic es);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, bi, 1'b0, em, ec, es, 1'b1);
    endtask

    task automatic idle(input logic em, input int ec, input logic es, input logic ea);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, em, ec, es, ea);
    endtask

    // Monitor: compare the DUT outputs shortly after each edge against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check($sformatf("c%0d.match", e.idx), match, e.m);
                check($sformatf("c%0d.count", e.idx), match_count, e.c);
                check($sformatf("c%0d.sat", e.idx), count_sat, e.s);
                check($sformatf("c%0d.armed", e.idx), armed, e.a);
            end
        end
    end

    initial begin
        // Reset, then bits offered while unconfigured are ignored.
        cyc(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 4'b0000, 0, 1, 1, 0, 0, 0, 0, 0);

        // Overlapping detection of 1011 over 1,0,1,1,0,1,1.
        cyc(0, 1, 4'b1011, 1, 0, 0, 0, 0, 0, 0, 1);
        send(1, 0, 0, 0);
        send(0, 0, 0, 0);
        send(1, 0, 0, 0);
        send(1, 1, 0, 0);
        send(0, 0, 1, 0);
        send(1, 0, 1, 0);
        send(1, 1, 1, 0);
        idle(0, 2, 0, 1);
        cyc(0, 0, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 1);

        // Non-overlapping: the completing bit is not reused.
        cyc(0, 1, 4'b1011, 0, 0, 0, 0, 0, 0, 0, 1);
        send(1, 0, 0, 0);
        send(0, 0, 0, 0);
        send(1, 0, 0, 0);
        send(1, 1, 0, 0);
        send(0, 0, 1, 0);
        send(1, 0, 1, 0);
        send(1, 0, 1, 0);
        idle(0, 1, 0, 1);

        // Invalid cycles interleaved carry bits that would break the pattern if shifted.
        cyc(0, 1, 4'b1011, 0, 0, 0, 0, 0, 1, 0, 1);
        send(1, 0, 1, 0);
        idle(0, 1, 0, 1);
        send(0, 0, 1, 0);
        cyc(0, 0, 4'b0000, 0, 0, 1, 0, 0, 1, 0, 1);
        send(1, 0, 1, 0);
        idle(0, 1, 0, 1);
        send(1, 1, 1, 0);
        idle(0, 2, 0, 1);

        // Reload on the would-be completing bit: no match, window and fill restart.
        send(1, 0, 2, 0);
        send(0, 0, 2, 0);
        send(1, 0, 2, 0);
        cyc(0, 1, 4'b1011, 1, 1, 1, 0, 0, 2, 0, 1);
        send(1, 0, 2, 0);
        send(0, 0, 2, 0);
        send(1, 0, 2, 0);
        send(1, 1, 2, 0);

        // Saturation at 3, then clear coinciding with a match pulse.
        send(0, 0, 3, 1);
        send(1, 0, 3, 1);
        send(1, 1, 3, 1);
        send(0, 0, 3, 1);
        send(1, 0, 3, 1);
        send(1, 1, 3, 1);
        cyc(0, 0, 4'b0000, 0, 0, 0, 1, 0, 1, 0, 1);
        send(0, 0, 1, 0);

        // Reset mid-hunt; stream ignored until the next load.
        cyc(1, 0, 4'b0000, 0, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 4'b0000, 0, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 4'b0000, 0, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 4'b0000, 0, 1, 1, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0);

        // Reload right after a match: pulse already out, counter still advances.
        cyc(0, 1, 4'b1011, 1, 0, 0, 0, 0, 0, 0, 1);
        send(1, 0, 0, 0);
        send(0, 0, 0, 0);
        send(1, 0, 0, 0);
        send(1, 1, 0, 0);
        cyc(0, 1, 4'b0000, 1, 1, 1, 0, 0, 1, 0, 1);

        // All-zero pattern must still wait for a full window.
        send(0, 0, 1, 0);
        send(0, 0, 1, 0);
        send(0, 0, 1, 0);
        send(0, 1, 1, 0);
        send(0, 1, 2, 0);
        idle(0, 3, 1, 1);

        repeat (2) @(posedge clk);
        #5;
        check("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
